// File: rtl/game_pkg.sv
// Shared types and constants for the rhythm-game screen flow.
//   screen_state_t : screen sequence START -> COUNTDOWN -> PLAY (-> PAUSE) -> OVER
//   screen_flags_t : one-hot screen-select flags driven to the drawing logic
//   KEY_*          : USB HID keycodes of the keys the game reacts to
//   flags_of()     : maps a screen state to its screen-select flags
package game_pkg;

    typedef enum logic [2:0] {
        START     = 3'd0,
        COUNTDOWN = 3'd1,
        PLAY      = 3'd2,
        PAUSE     = 3'd3,
        OVER      = 3'd4
    } screen_state_t;

    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_ESC   = 8'h29;

    typedef struct packed {
        logic start_screen;
        logic countdown_active;
        logic play_active;
        logic over_screen;
    } screen_flags_t;

    // PAUSE has no flag in this set; its flag is the separate paused output.
    function automatic screen_flags_t flags_of(input screen_state_t s);
        screen_flags_t f;
        f = 4'b0000;
        case (s)
            START:     f.start_screen     = 1'b1;
            COUNTDOWN: f.countdown_active = 1'b1;
            PLAY:      f.play_active      = 1'b1;
            PAUSE:     f = 4'b0000;
            OVER:      f.over_screen      = 1'b1;
            default:   f.start_screen     = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Watches every keycode slot of the keyboard report for one keycode.
//   frame_clk : frame-rate clock
//   Reset_n   : synchronous active-low reset (clears key history)
//   keycode   : keyboard report, slot i = keycode[8i+7:8i]
//   present   : KEY is in at least one slot this frame
//   press     : KEY is present now but was not present last frame
module key_edge_detect
    import game_pkg::*;
#(
    parameter int         NUM_KEYS = 6,
    parameter logic [7:0] KEY      = KEY_SPACE
) (
    input  logic                  frame_clk,
    input  logic                  Reset_n,
    input  logic [8*NUM_KEYS-1:0] keycode,
    output logic                  present,
    output logic                  press
);

    logic present_s;
    logic present_q_r;

    // OR of slot matches: a code repeated in several slots is still one key.
    always_comb begin
        present_s = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (keycode[8*i +: 8] == KEY) begin
                present_s = 1'b1;
            end else begin
                present_s = present_s;
            end
        end
    end

    // Key history, one frame deep.
    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            present_q_r <= 1'b0;
        end else begin
            present_q_r <= present_s;
        end
    end

    assign present = present_s;
    assign press   = present_s & ~present_q_r;

endmodule

// File: rtl/screen_sequencer.sv
// Game-flow controller, clocked once per video frame.
// Sequence: START -> COUNTDOWN -> PLAY -> OVER -> START.
// Optional macro GAME_PAUSE_EN adds a PAUSE state entered/left from PLAY
// with PAUSE_KEY; without it, paused is tied low and PAUSE_KEY is ignored.
// Ports:
//   frame_clk        : frame-rate clock, all state updates on rising edge
//   Reset_n          : synchronous active-low reset
//   keycode          : keyboard report, NUM_KEYS slots of 8 bits (00 = empty)
//   song_done        : song player reports the chart has ended
//   start_screen     : high in START
//   countdown_active : high in COUNTDOWN
//   play_active      : high in PLAY
//   over_screen      : high in OVER
//   paused           : high in PAUSE
//   text_blink       : prompt-text visibility in START/OVER, else 0
//   countdown_digit  : digit shown in COUNTDOWN, else 0
//   song_start       : one-frame pulse on entry to PLAY from COUNTDOWN
module screen_sequencer
    import game_pkg::*;
#(
    parameter int         NUM_KEYS       = 6,
    parameter int         FRAMES_PER_SEC = 60,
    parameter int         COUNTDOWN_SECS = 3,
    parameter int         BLINK_FRAMES   = 30,
    parameter logic [7:0] START_KEY      = KEY_SPACE,
    parameter logic [7:0] RESTART_KEY    = KEY_ENTER
`ifdef GAME_PAUSE_EN
    ,
    parameter logic [7:0] PAUSE_KEY      = KEY_ESC
`endif
) (
    input  logic                  frame_clk,
    input  logic                  Reset_n,
    input  logic [8*NUM_KEYS-1:0] keycode,
    input  logic                  song_done,
    output logic                  start_screen,
    output logic                  countdown_active,
    output logic                  play_active,
    output logic                  over_screen,
    output logic                  paused,
    output logic                  text_blink,
    output logic [3:0]            countdown_digit,
    output logic                  song_start
);

    // Widths hold the full count value so that no parameter choice overflows.
    localparam int FRAME_CNT_W = $clog2(FRAMES_PER_SEC + 1);
    localparam int BLINK_CNT_W = $clog2(BLINK_FRAMES + 1);

    localparam logic [FRAME_CNT_W-1:0] FRAME_ZERO  = {FRAME_CNT_W{1'b0}};
    localparam logic [FRAME_CNT_W-1:0] FRAME_ONE   = FRAME_CNT_W'(1);
    localparam logic [FRAME_CNT_W-1:0] FRAME_LAST  = FRAME_CNT_W'(FRAMES_PER_SEC - 1);
    localparam logic [BLINK_CNT_W-1:0] BLINK_ZERO  = {BLINK_CNT_W{1'b0}};
    localparam logic [BLINK_CNT_W-1:0] BLINK_ONE   = BLINK_CNT_W'(1);
    localparam logic [BLINK_CNT_W-1:0] BLINK_LAST  = BLINK_CNT_W'(BLINK_FRAMES - 1);
    localparam logic [3:0]             DIGIT_FIRST = 4'(COUNTDOWN_SECS);

    screen_state_t            state_r;
    screen_flags_t            flags_r;
    logic                     text_blink_r;
    logic [BLINK_CNT_W-1:0]   blink_cnt_r;
    logic [FRAME_CNT_W-1:0]   frame_cnt_r;
    logic [3:0]               digit_r;
    logic                     song_start_r;

    logic start_press_s;
    logic restart_press_s;
    logic start_present_unused_s;
    logic restart_present_unused_s;

    key_edge_detect #(
        .NUM_KEYS (NUM_KEYS),
        .KEY      (START_KEY)
    ) u_start_key (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .keycode   (keycode),
        .present   (start_present_unused_s),
        .press     (start_press_s)
    );

    key_edge_detect #(
        .NUM_KEYS (NUM_KEYS),
        .KEY      (RESTART_KEY)
    ) u_restart_key (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .keycode   (keycode),
        .present   (restart_present_unused_s),
        .press     (restart_press_s)
    );

`ifdef GAME_PAUSE_EN
    logic pause_press_s;
    logic pause_present_unused_s;
    logic paused_r;

    key_edge_detect #(
        .NUM_KEYS (NUM_KEYS),
        .KEY      (PAUSE_KEY)
    ) u_pause_key (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .keycode   (keycode),
        .present   (pause_present_unused_s),
        .press     (pause_press_s)
    );
`endif

    // Screen FSM with all outputs registered alongside the state.
    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            state_r      <= START;
            flags_r      <= flags_of(START);
            text_blink_r <= 1'b1;
            blink_cnt_r  <= BLINK_ZERO;
            frame_cnt_r  <= FRAME_ZERO;
            digit_r      <= 4'd0;
            song_start_r <= 1'b0;
`ifdef GAME_PAUSE_EN
            paused_r     <= 1'b0;
`endif
        end else begin
            song_start_r <= 1'b0;
            case (state_r)
                START: begin
                    if (start_press_s) begin
                        state_r      <= COUNTDOWN;
                        flags_r      <= flags_of(COUNTDOWN);
                        digit_r      <= DIGIT_FIRST;
                        frame_cnt_r  <= FRAME_ZERO;
                        text_blink_r <= 1'b0;
                        blink_cnt_r  <= BLINK_ZERO;
                    end else if (blink_cnt_r == BLINK_LAST) begin
                        blink_cnt_r  <= BLINK_ZERO;
                        text_blink_r <= ~text_blink_r;
                    end else begin
                        blink_cnt_r  <= blink_cnt_r + BLINK_ONE;
                    end
                end
                COUNTDOWN: begin
                    if (frame_cnt_r == FRAME_LAST) begin
                        frame_cnt_r <= FRAME_ZERO;
                        if (digit_r > 4'd1) begin
                            digit_r <= digit_r - 4'd1;
                        end else begin
                            // Last second elapsed: song starts on the first PLAY frame.
                            state_r      <= PLAY;
                            flags_r      <= flags_of(PLAY);
                            digit_r      <= 4'd0;
                            song_start_r <= 1'b1;
                        end
                    end else begin
                        frame_cnt_r <= frame_cnt_r + FRAME_ONE;
                    end
                end
                PLAY: begin
                    // End of song wins over any key event in the same frame.
                    if (song_done) begin
                        state_r      <= OVER;
                        flags_r      <= flags_of(OVER);
                        text_blink_r <= 1'b1;
                        blink_cnt_r  <= BLINK_ZERO;
                    end
`ifdef GAME_PAUSE_EN
                    else if (pause_press_s) begin
                        state_r  <= PAUSE;
                        flags_r  <= flags_of(PAUSE);
                        paused_r <= 1'b1;
                    end
`endif
                    else begin
                        state_r <= PLAY;
                    end
                end
                PAUSE: begin
`ifdef GAME_PAUSE_EN
                    // Resume without a song_start pulse; song_done is not looked at here.
                    if (pause_press_s) begin
                        state_r  <= PLAY;
                        flags_r  <= flags_of(PLAY);
                        paused_r <= 1'b0;
                    end else begin
                        state_r <= PAUSE;
                    end
`else
                    // Unreachable in this build; fall back to the start screen.
                    state_r      <= START;
                    flags_r      <= flags_of(START);
                    text_blink_r <= 1'b1;
                    blink_cnt_r  <= BLINK_ZERO;
                    digit_r      <= 4'd0;
`endif
                end
                OVER: begin
                    if (restart_press_s) begin
                        state_r      <= START;
                        flags_r      <= flags_of(START);
                        text_blink_r <= 1'b1;
                        blink_cnt_r  <= BLINK_ZERO;
                    end else if (blink_cnt_r == BLINK_LAST) begin
                        blink_cnt_r  <= BLINK_ZERO;
                        text_blink_r <= ~text_blink_r;
                    end else begin
                        blink_cnt_r  <= blink_cnt_r + BLINK_ONE;
                    end
                end
                default: begin
                    // Illegal encoding: recover to the start screen.
                    state_r      <= START;
                    flags_r      <= flags_of(START);
                    text_blink_r <= 1'b1;
                    blink_cnt_r  <= BLINK_ZERO;
                    frame_cnt_r  <= FRAME_ZERO;
                    digit_r      <= 4'd0;
`ifdef GAME_PAUSE_EN
                    paused_r     <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign start_screen     = flags_r.start_screen;
    assign countdown_active = flags_r.countdown_active;
    assign play_active      = flags_r.play_active;
    assign over_screen      = flags_r.over_screen;
    assign text_blink       = text_blink_r;
    assign countdown_digit  = digit_r;
    assign song_start       = song_start_r;
`ifdef GAME_PAUSE_EN
    assign paused           = paused_r;
`else
    assign paused           = 1'b0;
`endif

endmodule

// File: tb/tb_screen_sequencer.sv
// Self-checking bench for screen_sequencer with a frame-level reference model.
module tb_screen_sequencer;

    localparam int NK    = 6;
    localparam int FPS   = 4;
    localparam int SECS  = 3;
    localparam int BLINK = 2;

    localparam int S_START = 0;
    localparam int S_CD    = 1;
    localparam int S_PLAY  = 2;
    localparam int S_PAUSE = 3;
    localparam int S_OVER  = 4;

`ifdef GAME_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic            frame_clk;
    logic            Reset_n;
    logic [8*NK-1:0] keycode;
    logic            song_done;
    logic            start_screen;
    logic            countdown_active;
    logic            play_active;
    logic            over_screen;
    logic            paused;
    logic            text_blink;
    logic [3:0]      countdown_digit;
    logic            song_start;

    screen_sequencer #(
        .NUM_KEYS       (NK),
        .FRAMES_PER_SEC (FPS),
        .COUNTDOWN_SECS (SECS),
        .BLINK_FRAMES   (BLINK)
    ) dut (
        .frame_clk        (frame_clk),
        .Reset_n          (Reset_n),
        .keycode          (keycode),
        .song_done        (song_done),
        .start_screen     (start_screen),
        .countdown_active (countdown_active),
        .play_active      (play_active),
        .over_screen      (over_screen),
        .paused           (paused),
        .text_blink       (text_blink),
        .countdown_digit  (countdown_digit),
        .song_start       (song_start)
    );

    initial begin
        frame_clk = 1'b0;
        forever #5 frame_clk = ~frame_clk;
    end

    int         n_vec;
    int         n_miss;
    logic [7:0] kc_slots [NK];

    // Reference model: screen, frames spent in it, song pulse, key history.
    int m_screen;
    int m_frames;
    bit m_pulse;
    bit m_prev_space;
    bit m_prev_enter;
    bit m_prev_esc;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit slots_have(input logic [7:0] k);
        for (int i = 0; i < NK; i++) begin
            if (kc_slots[i] == k) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic clear_keys();
        for (int i = 0; i < NK; i++) kc_slots[i] = 8'h00;
    endtask

    task automatic model_step(input logic rst_n_in, input logic done_in);
        bit ps, pe, px;
        int nxt;
        ps = slots_have(8'h2C);
        pe = slots_have(8'h28);
        px = slots_have(8'h29);
        m_pulse = 1'b0;
        if (!rst_n_in) begin
            m_screen = S_START;
            m_frames = 0;
            m_prev_space = 1'b0;
            m_prev_enter = 1'b0;
            m_prev_esc   = 1'b0;
            return;
        end
        nxt = m_screen;
        case (m_screen)
            S_START: if (ps && !m_prev_space) nxt = S_CD;
            S_CD: if (m_frames == SECS*FPS - 1) begin
                nxt = S_PLAY;
                m_pulse = 1'b1;
            end
            S_PLAY: begin
                if (done_in) nxt = S_OVER;
                else if (PAUSE_EN && px && !m_prev_esc) nxt = S_PAUSE;
            end
            S_PAUSE: if (px && !m_prev_esc) nxt = S_PLAY;
            S_OVER: if (pe && !m_prev_enter) nxt = S_START;
            default: nxt = S_START;
        endcase
        if (nxt != m_screen) m_frames = 0;
        else m_frames++;
        m_screen = nxt;
        m_prev_space = ps;
        m_prev_enter = pe;
        m_prev_esc   = px;
    endtask

    // One frame: drive inputs, clock, advance model, check every output.
    task automatic frame(input logic rst_n_in, input logic done_in);
        logic       e_blink;
        logic [3:0] e_digit;
        for (int i = 0; i < NK; i++) keycode[8*i +: 8] = kc_slots[i];
        Reset_n   = rst_n_in;
        song_done = done_in;
        @(posedge frame_clk);
        model_step(rst_n_in, done_in);
        #1;
        e_blink = (m_screen == S_START || m_screen == S_OVER) ? (((m_frames / BLINK) % 2) == 0) : 1'b0;
        e_digit = (m_screen == S_CD) ? 4'(SECS - m_frames / FPS) : 4'd0;
        n_vec++;
        chk("start_screen",     start_screen,     m_screen == S_START);
        chk("countdown_active", countdown_active, m_screen == S_CD);
        chk("play_active",      play_active,      m_screen == S_PLAY);
        chk("over_screen",      over_screen,      m_screen == S_OVER);
        chk("paused",           paused,           m_screen == S_PAUSE);
        chk("text_blink",       text_blink,       e_blink);
        chk("countdown_digit",  countdown_digit,  e_digit);
        chk("song_start",       song_start,       m_pulse);
    endtask

    bit         exp_blink  [8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] exp_digits [12] = '{4'd3, 4'd3, 4'd3, 4'd3, 4'd2, 4'd2, 4'd2, 4'd2,
                                    4'd1, 4'd1, 4'd1, 4'd1};

    initial begin
        int pulses;
        int r;
        n_vec = 0;
        n_miss = 0;
        m_screen = S_START;
        m_frames = 0;
        clear_keys();
        Reset_n = 1'b0;
        song_done = 1'b0;
        keycode = '0;

        // Reset then idle: blink pattern 1,1,0,0,1,1,0,0.
        frame(1'b0, 1'b0);
        chk("reset_start", start_screen, 1'b1);
        chk("blink_seq", text_blink, exp_blink[0]);
        for (int i = 1; i < 8; i++) begin
            frame(1'b1, 1'b0);
            chk("blink_seq", text_blink, exp_blink[i]);
        end

        // Space in slot 5: full countdown then PLAY with one song_start.
        kc_slots[5] = 8'h2C;
        frame(1'b1, 1'b0);
        chk("cd_entry", countdown_active, 1'b1);
        chk("cd_digit", countdown_digit, exp_digits[0]);
        clear_keys();
        for (int i = 1; i < 12; i++) begin
            frame(1'b1, 1'b0);
            chk("cd_digit", countdown_digit, exp_digits[i]);
        end
        frame(1'b1, 1'b0);
        chk("play_entry", play_active, 1'b1);
        chk("song_pulse", song_start, 1'b1);
        frame(1'b1, 1'b0);
        chk("song_pulse_end", song_start, 1'b0);
        frame(1'b1, 1'b1);
        chk("over_entry", over_screen, 1'b1);
        kc_slots[1] = 8'h28;
        frame(1'b1, 1'b0);
        chk("restart", start_screen, 1'b1);
        clear_keys();
        frame(1'b1, 1'b0);

        // Space held from START through PLAY, song ends, space ignored in OVER.
        kc_slots[2] = 8'h2C;
        for (int i = 0; i < 16; i++) frame(1'b1, 1'b0);
        chk("held_play", play_active, 1'b1);
        frame(1'b1, 1'b1);
        chk("held_over", over_screen, 1'b1);
        frame(1'b1, 1'b0);
        kc_slots[2] = 8'h00;
        frame(1'b1, 1'b0);
        kc_slots[2] = 8'h2C;
        frame(1'b1, 1'b0);
        chk("space_in_over", over_screen, 1'b1);
        kc_slots[4] = 8'h28;
        frame(1'b1, 1'b0);
        chk("enter_start", start_screen, 1'b1);
        chk("enter_blink", text_blink, 1'b1);
        clear_keys();
        frame(1'b1, 1'b0);

        // Reset during digit 2.
        kc_slots[0] = 8'h2C;
        frame(1'b1, 1'b0);
        clear_keys();
        for (int i = 0; i < 4; i++) frame(1'b1, 1'b0);
        chk("digit_two", countdown_digit, 4'd2);
        frame(1'b0, 1'b0);
        chk("rst_mid_start", start_screen, 1'b1);
        chk("rst_mid_digit", countdown_digit, 4'd0);
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            frame(1'b1, 1'b0);
            pulses += int'(song_start);
        end
        chk("no_pulse_after_reset", 8'(pulses), 8'd0);

        // Same code in two slots: one press; dropping one slot does not retrigger.
        kc_slots[0] = 8'h2C;
        kc_slots[3] = 8'h2C;
        frame(1'b1, 1'b0);
        chk("dual_entry", countdown_active, 1'b1);
        kc_slots[3] = 8'h00;
        frame(1'b1, 1'b0);
        chk("dual_digit", countdown_digit, 4'd3);
        for (int i = 0; i < 11; i++) frame(1'b1, 1'b0);
        chk("dual_play", play_active, 1'b1);
        frame(1'b1, 1'b1);
        kc_slots[3] = 8'h2C;
        kc_slots[1] = 8'h28;
        frame(1'b1, 1'b0);
        chk("dual_restart", start_screen, 1'b1);
        kc_slots[1] = 8'h00;
        kc_slots[3] = 8'h00;
        frame(1'b1, 1'b0);
        chk("dual_no_retrig", start_screen, 1'b1);
        frame(1'b1, 1'b0);
        chk("dual_no_retrig2", start_screen, 1'b1);
        clear_keys();
        frame(1'b1, 1'b0);

        // Escape in PLAY.
        kc_slots[0] = 8'h2C;
        frame(1'b1, 1'b0);
        clear_keys();
        for (int i = 0; i < 12; i++) frame(1'b1, 1'b0);
        kc_slots[0] = 8'h29;
        frame(1'b1, 1'b0);
`ifdef GAME_PAUSE_EN
        chk("pause_on", paused, 1'b1);
        chk("pause_play_off", play_active, 1'b0);
        frame(1'b1, 1'b1);
        clear_keys();
        frame(1'b1, 1'b1);
        chk("pause_ignores_done", paused, 1'b1);
        kc_slots[0] = 8'h29;
        frame(1'b1, 1'b1);
        chk("resume_play", play_active, 1'b1);
        chk("resume_no_pulse", song_start, 1'b0);
        clear_keys();
`else
        chk("esc_ignored", play_active, 1'b1);
        chk("paused_tied", paused, 1'b0);
        clear_keys();
`endif
        frame(1'b1, 1'b1);
        chk("final_over", over_screen, 1'b1);
        kc_slots[2] = 8'h28;
        frame(1'b1, 1'b0);
        clear_keys();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NK; i++) begin
                r = int'($urandom_range(0, 11));
                if (r < 6)       kc_slots[i] = 8'h00;
                else if (r < 8)  kc_slots[i] = 8'h2C;
                else if (r == 8) kc_slots[i] = 8'h28;
                else if (r == 9) kc_slots[i] = 8'h29;
                else             kc_slots[i] = 8'($urandom_range(1, 255));
            end
            frame(($urandom_range(0, 299) != 0), ($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/screen_sequencer.md
Name: screen_sequencer

Overview:
- Parametrised game-flow controller for the rhythm game, clocked once per video frame.
- Replaces the two-state start-screen latch with a full screen sequence: START -> COUNTDOWN -> PLAY -> OVER -> START.
- Scans every keycode slot of the USB keyboard report and edge-detects key presses.
- Drives screen-select flags, a blinking-text enable, a countdown digit and a one-frame song-start pulse to the sprite/text drawing logic and the song player.

Parameters:
- NUM_KEYS, 6, number of 8-bit keycode slots in the keyboard report.
- FRAMES_PER_SEC, 60, frames per countdown step.
- COUNTDOWN_SECS, 3, first countdown digit shown; range 1..9.
- BLINK_FRAMES, 30, frames per half-period of the blinking prompt text.
- START_KEY, 8'h2C, keycode that starts the game (space).
- RESTART_KEY, 8'h28, keycode that leaves OVER (enter).

Ports:
- frame_clk  input  1  frame-rate clock; all state updates on its rising edge.
- Reset_n  input  1  synchronous active-low reset.
- keycode  input  8*NUM_KEYS  keyboard report; slot i = keycode[8i+7:8i]; 8'h00 = empty slot.
- song_done  input  1  level from the song player; high when the chart has ended.
- start_screen  output  1  high in START.
- countdown_active  output  1  high in COUNTDOWN.
- play_active  output  1  high in PLAY.
- over_screen  output  1  high in OVER.
- paused  output  1  high in PAUSE; tied 0 without GAME_PAUSE_EN.
- text_blink  output  1  prompt-text visibility in START/OVER; 0 in all other states.
- countdown_digit  output  4  digit to draw in COUNTDOWN; 0 otherwise.
- song_start  output  1  one-frame pulse on entry to PLAY.

Behaviour:
- Reset (Reset_n == 0 at the clock edge):
  - state = START, start_screen = 1, all other flags 0.
  - text_blink = 1, countdown_digit = 0, song_start = 0.
  - frame and blink counters = 0, key history = 0.
  - Reset applies in any state, including mid-countdown or mid-PLAY.
- Key detection:
  - present(K) = OR over all slots of (slot == K).
  - press(K) = present(K) & ~present_q(K); present_q is registered every frame.
  - A key held across a state change never re-triggers. A code appearing in several slots counts as one press.
- START:
  - text_blink toggles every BLINK_FRAMES frames.
  - press(START_KEY) -> COUNTDOWN next frame; load countdown_digit = COUNTDOWN_SECS, frame counter = 0.
- COUNTDOWN:
  - Frame counter counts 0..FRAMES_PER_SEC-1 and wraps.
  - On wrap with digit > 1: digit decrements.
  - On wrap with digit == 1: go to PLAY; song_start = 1 for exactly that first PLAY frame; digit = 0.
  - Key presses are ignored.
  - Total COUNTDOWN duration = COUNTDOWN_SECS*FRAMES_PER_SEC frames.
- PLAY:
  - song_done high -> OVER next frame. The song_done check takes priority over any key event in the same frame.
- OVER:
  - On entry: text_blink = 1, blink counter = 0; blinking continues as in START.
  - press(RESTART_KEY) -> START; text_blink = 1, blink counter = 0 on entry.
  - START_KEY is ignored in OVER.
- Outputs are registered: exactly one screen flag is high in every frame.
- Counter widths: $clog2 of the largest count + 1. No counter may overflow at any legal parameter value.

Optional Feature:
- Macro: GAME_PAUSE_EN.
- Defined:
  - Adds state PAUSE and parameter PAUSE_KEY = 8'h29 (escape).
  - press(PAUSE_KEY) in PLAY -> PAUSE; paused = 1, play_active = 0.
  - In PAUSE, press(PAUSE_KEY) -> PLAY without a song_start pulse.
  - song_done is ignored while in PAUSE.
- Undefined:
  - No PAUSE state; paused tied to 0; PAUSE_KEY is ignored.

Decomposition:
- Package game_pkg holds:
  - screen_state_t enum {START, COUNTDOWN, PLAY, PAUSE, OVER}.
  - Keycode constants KEY_SPACE = 8'h2C, KEY_ENTER = 8'h28, KEY_ESC = 8'h29.
- Sub-module key_edge_detect:
  - Parameters NUM_KEYS and KEY.
  - Returns the present/press pair for one keycode.
  - Instantiated once per watched key.

Test Plan (NUM_KEYS=6, FRAMES_PER_SEC=4, COUNTDOWN_SECS=3, BLINK_FRAMES=2):
- Reset then idle 8 frames -> start_screen = 1; text_blink sequence 1,1,0,0,1,1,0,0.
- Space (2C) in slot 5 only -> COUNTDOWN next frame; digits 3,3,3,3,2,2,2,2,1,1,1,1; then play_active = 1 with a single song_start pulse.
- Space held continuously from START through PLAY, then song_done = 1 -> OVER on the next frame; pressing space in OVER has no effect; enter (28) press -> START with text_blink = 1.
- Reset_n low during countdown digit 2 -> START next frame, countdown_digit = 0, song_start never pulses.
- Space present in slots 0 and 3 simultaneously -> exactly one transition; releasing one slot while the other holds does not re-trigger.
- GAME_PAUSE_EN defined: escape (29) in PLAY -> paused = 1; song_done = 1 while paused -> no transition; escape again -> PLAY with no song_start pulse; song_done -> OVER.
